// File: rtl/operand_stack_seq.sv
// ---------------------------------------------------------------------------
// stackCPU_DEFS : shared definitions for the stack CPU (opcode encoding and
//                 default datapath width).
//
// operand_stack_seq : LIFO operand stack plus execute sequencer.
//   Accepts one decoded instruction at a time over a valid/ready handshake.
//   It pops operands into the external combinational ALU and pushes the
//   result (or an immediate) back. Each instruction takes three cycles:
//   IDLE (accept) -> EXEC (drive ALU) -> WB (retire).
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   instr_valid/ready      decoder handshake; ready only while IDLE
//   instr_opcode/imm       decoded instruction; imm used by PUSH_IMMEDIATE
//   alu_operand1/2, alu_opcode   registered drive into the ALU in EXEC
//   alu_result, alu_error  ALU response, captured at the end of EXEC
//   done, err, err_code    retire pulse in WB with error status
//   tos, count, empty, full   architectural stack state
// ---------------------------------------------------------------------------
package stackCPU_DEFS;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        ADD            = 4'd0,
        SUB            = 4'd1,
        MUL            = 4'd2,
        DIV            = 4'd3,
        MOD            = 4'd4,
        AND            = 4'd5,
        OR             = 4'd6,
        INVERT         = 4'd7,
        PUSH_IMMEDIATE = 4'd8
    } opcode_t;
endpackage

module operand_stack_seq #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = stackCPU_DEFS::DATA_WIDTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  stackCPU_DEFS::opcode_t             instr_opcode,
    input  logic signed [DATA_WIDTH-1:0]       instr_imm,
    output logic signed [DATA_WIDTH-1:0]       alu_operand1,
    output logic signed [DATA_WIDTH-1:0]       alu_operand2,
    output stackCPU_DEFS::opcode_t             alu_opcode,
    input  logic signed [DATA_WIDTH-1:0]       alu_result,
    input  logic                               alu_error,
    output logic                               done,
    output logic                               err,
    output logic [1:0]                         err_code,
    output logic signed [DATA_WIDTH-1:0]       tos,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               empty,
    output logic                               full
);
    import stackCPU_DEFS::*;

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    // Everything EXEC and WB need is captured at accept time, so the
    // decoder inputs are free to change once the handshake completes.
    typedef struct packed {
        opcode_t                      op;
        logic signed [DATA_WIDTH-1:0] imm;
        logic signed [DATA_WIDTH-1:0] tos;
        logic signed [DATA_WIDTH-1:0] nos;
    } snap_t;

    state_t                        state, state_nx;
    snap_t                         snap;
    logic signed [DATA_WIDTH-1:0]  mem [DEPTH];
    logic signed [DATA_WIDTH-1:0]  res_q;
    logic                          aerr_q;
    logic [CW-1:0]                 cnt_q;
    logic signed [DATA_WIDTH-1:0]  tos_q;

    logic                          accept;
    logic [CW-1:0]                 nos_ptr;
    logic signed [DATA_WIDTH-1:0]  nos_rd;
    logic                          op_bin, op_inv, op_push;
    logic                          underflow, overflow;
    logic [1:0]                    code;
    logic                          commit;
    logic [CW-1:0]                 wr_ptr;
    logic [CW-1:0]                 cnt_nx;
    logic signed [DATA_WIDTH-1:0]  wr_data;

    function automatic logic is_binary(input opcode_t op);
        case (op)
            ADD, SUB, MUL, DIV, MOD, AND, OR: is_binary = 1'b1;
            default:                          is_binary = 1'b0;
        endcase
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = (state == IDLE);
        case (state)
            IDLE:    if (instr_valid) state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && instr_valid;

    // NOS lives at entry count-2; only read it when it exists.
    assign nos_ptr = cnt_q - CW'(2);
    assign nos_rd  = (cnt_q >= CW'(2)) ? mem[nos_ptr[AW-1:0]] : '0;

    // ---------------- ALU drive ----------------
    always_comb begin
        alu_opcode   = PUSH_IMMEDIATE;
        alu_operand1 = '0;
        alu_operand2 = '0;
        if (state == EXEC) begin
            alu_opcode = snap.op;
            if (is_binary(snap.op)) begin
                alu_operand1 = snap.nos;
                alu_operand2 = snap.tos;
            end else if (snap.op == INVERT) begin
                alu_operand2 = snap.tos;
            end
        end
    end

    // ---------------- Writeback decode ----------------
    assign op_bin  = is_binary(snap.op);
    assign op_inv  = (snap.op == INVERT);
    assign op_push = (snap.op == PUSH_IMMEDIATE);

    assign underflow = (op_bin && (cnt_q < CW'(2))) || (op_inv && (cnt_q == '0));
    assign overflow  = op_push && (cnt_q == CW'(DEPTH));

    always_comb begin
        if (underflow)     code = 2'd1;
        else if (overflow) code = 2'd2;
        else if (aerr_q)   code = 2'd3;
        else               code = 2'd0;
    end

    assign done     = (state == WB);
    assign err      = done && (code != 2'd0);
    assign err_code = done ? code : 2'd0;

    // An opcode the sequencer does not know only retires cleanly if the ALU
    // did not flag it; the stack is left alone in that case too.
    assign commit  = done && (code == 2'd0) && (op_bin || op_inv || op_push);
    assign wr_data = op_push ? snap.imm : res_q;

    always_comb begin
        wr_ptr = cnt_q;
        cnt_nx = cnt_q;
        if (op_bin) begin
            wr_ptr = cnt_q - CW'(2);
            cnt_nx = cnt_q - CW'(1);
        end else if (op_inv) begin
            wr_ptr = cnt_q - CW'(1);
        end else if (op_push) begin
            cnt_nx = cnt_q + CW'(1);
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap   <= '{op: PUSH_IMMEDIATE, imm: '0, tos: '0, nos: '0};
            res_q  <= '0;
            aerr_q <= 1'b0;
            cnt_q  <= '0;
            tos_q  <= '0;
        end else begin
            if (accept) begin
                snap.op  <= instr_opcode;
                snap.imm <= instr_imm;
                snap.tos <= tos_q;
                snap.nos <= nos_rd;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                aerr_q <= alu_error;
            end
            if (commit) begin
                cnt_q <= cnt_nx;
                tos_q <= wr_data;   // the written entry is always the new top
            end
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign tos   = tos_q;
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule
